// File: rtl/spi_cmd_regbank.sv
// Register-access command decoder behind the SPI16 slave: single write/read and burst write
// into a bank of 8-bit control registers. Define SPI_CMD_TIMEOUT_EN to enable the burst timeout.
module spi_cmd_regbank #(
   parameter int unsigned ADDR_W    = 4,
   parameter int unsigned TO_W      = 16,
   parameter int unsigned TO_CYCLES = 50000
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [15:0]                 DATA,
   input  logic                        VALID,
   output logic [8*(1 << ADDR_W)-1:0]  REG_OUT,
   output logic                        WR_STROBE,
   output logic [ADDR_W-1:0]           WR_ADDR,
   output logic [7:0]                  RD_DATA,
   output logic                        RD_VALID,
   output logic                        BUSY,
   output logic                        ERR
);

   localparam int unsigned NUM_REGS = 1 << ADDR_W;

   if (ADDR_W < 1 || ADDR_W > 6) begin : g_bad_addr_w
      $error("ADDR_W must be 1..6");
   end
   if (TO_CYCLES == 0 || TO_W > 31 || TO_CYCLES >= (1 << TO_W)) begin : g_bad_to
      $error("TO_CYCLES must be in 1..2**TO_W-1");
   end

   typedef enum logic [0:0] {StIdle, StBurst} state_e;
   typedef enum logic [1:0] {OpNop, OpWrite, OpRead, OpBurst} op_e;

   state_e              state_q, state_d;
   logic [7:0]          regs_q [NUM_REGS];
   logic [7:0]          regs_d [NUM_REGS];
   logic [ADDR_W-1:0]   ptr_q, ptr_d;
   logic [7:0]          rem_q, rem_d;
   logic [7:0]          rd_data_q, rd_data_d;
   logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
   logic                wr_strobe_q, wr_strobe_d;
   logic                rd_valid_q, rd_valid_d;
   logic                err_q, err_d;
`ifdef SPI_CMD_TIMEOUT_EN
   logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
`endif

   op_e                 op;
   logic [5:0]          addr_raw;
   logic [ADDR_W-1:0]   cmd_addr;
   logic [7:0]          arg;
   logic                addr_oor;
   logic [ADDR_W-1:0]   ptr_nxt;

   assign op       = op_e'(DATA[15:14]);
   assign addr_raw = DATA[13:8];
   assign cmd_addr = DATA[8 +: ADDR_W];
   assign arg      = DATA[7:0];
   // Any address bit above the implemented width makes the command invalid.
   assign addr_oor = (addr_raw >> ADDR_W) != 6'd0;
   assign ptr_nxt  = ptr_q + 1'b1;

   always_comb begin
      state_d     = state_q;
      regs_d      = regs_q;
      ptr_d       = ptr_q;
      rem_d       = rem_q;
      rd_data_d   = rd_data_q;
      wr_addr_d   = wr_addr_q;
      wr_strobe_d = 1'b0;
      rd_valid_d  = 1'b0;
      err_d       = 1'b0;
`ifdef SPI_CMD_TIMEOUT_EN
      to_cnt_d    = to_cnt_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (VALID) begin
               if (op != OpNop && addr_oor) begin
                  err_d = 1'b1;
               end else begin
                  unique case (op)
                     OpWrite: begin
                        regs_d[cmd_addr] = arg;
                        wr_strobe_d      = 1'b1;
                        wr_addr_d        = cmd_addr;
                     end
                     OpRead: begin
                        rd_data_d  = regs_q[cmd_addr];
                        rd_valid_d = 1'b1;
                     end
                     OpBurst: begin
                        if (arg != 8'd0) begin
                           state_d  = StBurst;
                           ptr_d    = cmd_addr;
                           rem_d    = arg;
`ifdef SPI_CMD_TIMEOUT_EN
                           to_cnt_d = TO_W'(TO_CYCLES);
`endif
                        end
                     end
                     default: ;
                  endcase
               end
            end
         end
         StBurst: begin
            if (VALID) begin
               regs_d[ptr_q]   = DATA[15:8];
               regs_d[ptr_nxt] = DATA[7:0];
               wr_strobe_d     = 1'b1;
               wr_addr_d       = ptr_q;
               ptr_d           = ptr_q + ADDR_W'(2);
               rem_d           = rem_q - 8'd1;
               if (rem_q == 8'd1) begin
                  state_d = StIdle;
               end
`ifdef SPI_CMD_TIMEOUT_EN
               to_cnt_d = TO_W'(TO_CYCLES);
            end else if (to_cnt_q == TO_W'(1)) begin
               // Counter hits zero this cycle: abandon the burst, keep what was written.
               to_cnt_d = '0;
               err_d    = 1'b1;
               state_d  = StIdle;
            end else begin
               to_cnt_d = to_cnt_q - TO_W'(1);
`endif
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         regs_q      <= '{default: '0};
         ptr_q       <= '0;
         rem_q       <= '0;
         rd_data_q   <= '0;
         wr_addr_q   <= '0;
         wr_strobe_q <= 1'b0;
         rd_valid_q  <= 1'b0;
         err_q       <= 1'b0;
`ifdef SPI_CMD_TIMEOUT_EN
         to_cnt_q    <= '0;
`endif
      end else begin
         state_q     <= state_d;
         regs_q      <= regs_d;
         ptr_q       <= ptr_d;
         rem_q       <= rem_d;
         rd_data_q   <= rd_data_d;
         wr_addr_q   <= wr_addr_d;
         wr_strobe_q <= wr_strobe_d;
         rd_valid_q  <= rd_valid_d;
         err_q       <= err_d;
`ifdef SPI_CMD_TIMEOUT_EN
         to_cnt_q    <= to_cnt_d;
`endif
      end
   end

   always_comb begin
      REG_OUT = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         REG_OUT[8*i +: 8] = regs_q[i];
      end
   end

   assign WR_STROBE = wr_strobe_q;
   assign WR_ADDR   = wr_addr_q;
   assign RD_DATA   = rd_data_q;
   assign RD_VALID  = rd_valid_q;
   assign ERR       = err_q;
   assign BUSY      = (state_q == StBurst);

endmodule
